stream_merger: RTL
==================

Name: stream_merger

Overview:
- Reverse-direction companion to the operand splitter: merges two WIDTH-bit operand streams (A, B) back onto one shared bus.
- Each output word carries a source tag using the same convention as the splitter: select=1 means A, select=0 means B.
- Sits between the operand/result paths and the shared display/IO bus. Valid/ready handshake on every side, one holding register per input, registered output, round-robin arbitration.

Parameters:
- WIDTH, 4, data width of A, B and output.
- CNT_W, 8, width of the optional grant counters; unused unless STREAM_MERGER_STATS_EN is defined.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- a_valid  in  1  A word present.
- a_data  in  WIDTH  A word.
- a_ready  out  1  A holding register empty.
- b_valid  in  1  B word present.
- b_data  in  WIDTH  B word.
- b_ready  out  1  B holding register empty.
- out_valid  out  1  output register holds a word.
- out_data  out  WIDTH  merged word.
- out_select  out  1  source tag: 1=A, 0=B.
- out_ready  in  1  downstream accepts the word.
- a_grants  out  CNT_W  A words delivered; present only with STREAM_MERGER_STATS_EN.
- b_grants  out  CNT_W  B words delivered; present only with STREAM_MERGER_STATS_EN.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low.
  - Reset clears a_full, b_full, out_valid, out_data, out_select, last_grant and the counters.
  - After reset: a_ready=1, b_ready=1, out_valid=0, out_data=0, out_select=0.
  - Reset asserted mid-operation discards all held words immediately. No partial output survives.
- Readys: a_ready = ~a_full and b_ready = ~b_full, combinational from registers only. They do not depend on a_valid/b_valid or out_ready.
- Input accept: a_valid & a_ready at an edge latches a_data and sets a_full. B is symmetric.
- Output load condition: load = ~out_valid | out_ready.
- Arbitration at an edge with load=1:
  - Only A full: out_data<=A hold, out_select<=1, out_valid<=1, a_full<=0, last_grant<=A.
  - Only B full: same as above with out_select<=0, last_grant<=B.
  - Both full: grant the source that is not last_grant. Reset value of last_grant is B, so A wins the first tie.
  - Neither full: out_valid<=0; out_data and out_select hold their previous values.
- Stall: out_valid & ~out_ready means out_data and out_select stay stable and no grant occurs. Holding registers stay full and their readys stay low.
- Latency: word accepted at edge N is in its holding register after N, and on the output after N+1 at the earliest (2 cycles input-to-output).
- Throughput:
  - A single input sustains 1 word per 2 cycles, because ready drops while full.
  - Both inputs active with out_ready=1 give 1 word per cycle, alternating A,B,A,B.
- Accept and grant in the same cycle:
  - A holding register cannot be granted and refilled at the same edge, because ready was 0 when full.
  - A newly accepted word is never granted at its accept edge.
- Ordering: words from one source leave in arrival order. No word is duplicated or dropped.

Optional Feature:
- Macro: STREAM_MERGER_STATS_EN.
- Defined:
  - a_grants and b_grants increment on each A/B grant (load with a word moved to the output).
  - They saturate at all-ones and clear on reset.
- Undefined: the counter ports and logic are absent. Merge behaviour is cycle-identical.

Test Plan:
- Reset then idle, out_ready=1 -> a_ready=b_ready=1, out_valid=0 for 10 cycles.
- Single A word 4'h9 at cycle 0, out_ready=1 -> out_valid=1, out_data=9, out_select=1 two edges later. a_ready low for exactly 1 cycle.
- A=4'h3 and B=4'hC presented at the same edge, out_ready=1 -> output A(3, sel=1), then B(C, sel=0) on consecutive cycles.
- Continuous A stream 1..8 and B stream 9..F with out_ready=1 -> strict alternation A,B from the second output on. No loss and per-source order kept.
- out_ready=0 for 5 cycles with out_valid=1 -> out_data/out_select stable, a_ready=b_ready=0 once both held. On release, the words drain in round-robin order.
- rst_n pulsed low mid-stream with words held -> all outputs return to reset values asynchronously. With STREAM_MERGER_STATS_EN: counters show 0 after reset and count 255 and saturate with CNT_W=8 after 300 A grants.

Source files
------------

// File: rtl/stream_merger.sv
// stream_merger: round-robin merge of two operand streams (A, B) onto one tagged output bus.
// Define STREAM_MERGER_STATS_EN to add the saturating a_grants/b_grants counters.
module stream_merger #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a_valid,
    input  logic [WIDTH-1:0] a_data,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [WIDTH-1:0] b_data,
    output logic             b_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_select,
    input  logic             out_ready
`ifdef STREAM_MERGER_STATS_EN
    ,
    output logic [CNT_W-1:0] a_grants,
    output logic [CNT_W-1:0] b_grants
`endif
);

    logic             a_full_p0;
    logic             b_full_p0;
    logic [WIDTH-1:0] a_hold_p0;
    logic [WIDTH-1:0] b_hold_p0;
    logic             last_a;
    logic             load;
    logic             grant_a;
    logic             grant_b;

    assign a_ready = ~a_full_p0;
    assign b_ready = ~b_full_p0;
    assign load    = ~out_valid | out_ready;

    // last_a resets to 0 (B last), so A wins the first tie.
    assign grant_a = load & a_full_p0 & (~b_full_p0 | ~last_a);
    assign grant_b = load & b_full_p0 & (~a_full_p0 | last_a);

    // Stage p0: input holding registers
    always_ff @(posedge clk) begin
        if (a_valid & a_ready) a_hold_p0 <= a_data;
        if (b_valid & b_ready) b_hold_p0 <= b_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_full_p0 <= 1'b0;
            b_full_p0 <= 1'b0;
        end else begin
            if (a_valid & a_ready)  a_full_p0 <= 1'b1;
            else if (grant_a)       a_full_p0 <= 1'b0;
            if (b_valid & b_ready)  b_full_p0 <= 1'b1;
            else if (grant_b)       b_full_p0 <= 1'b0;
        end
    end

    // Stage p1: output register and arbitration history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_select <= 1'b0;
            last_a     <= 1'b0;
        end else if (load) begin
            out_valid <= grant_a | grant_b;
            if (grant_a) begin
                out_data   <= a_hold_p0;
                out_select <= 1'b1;
                last_a     <= 1'b1;
            end else if (grant_b) begin
                out_data   <= b_hold_p0;
                out_select <= 1'b0;
                last_a     <= 1'b0;
            end
        end
    end

`ifdef STREAM_MERGER_STATS_EN
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_grants <= '0;
            b_grants <= '0;
        end else begin
            if (grant_a) a_grants <= sat_inc(a_grants);
            if (grant_b) b_grants <= sat_inc(b_grants);
        end
    end
`endif

endmodule
